// File: rtl/kyber_pkg.sv
// Shared Kyber constants, FSM encoding and d-width helpers.
// KYBER_BD12_EN additionally admits d=12 (raw ByteDecode_12).
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_N = 256;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  function automatic logic d_legal(input logic [3:0] d);
    case (d)
      4'd1, 4'd4, 4'd5, 4'd10, 4'd11: return 1'b1;
`ifdef KYBER_BD12_EN
      4'd12: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  // A polynomial of 256 d-bit values always packs into exactly 32*d bytes.
  function automatic logic [8:0] bytes_per_poly(input logic [3:0] d);
    return {d, 5'b0};
  endfunction
endpackage

// File: rtl/decompress_stream_if.sv
// Byte-in / coefficient-out handshake bundle for decompress_stream.
// o_err_range is present only when KYBER_BD12_EN is defined.
interface decompress_stream_if;
  logic        i_start;
  logic [3:0]  i_d;
  logic [7:0]  i_byte;
  logic        i_byte_valid;
  logic        o_byte_ready;
  logic [11:0] o_coeff;
  logic        o_coeff_valid;
  logic        i_coeff_ready;
  logic [7:0]  o_idx;
  logic        o_last;
  logic        o_busy;
  logic        o_err;
`ifdef KYBER_BD12_EN
  logic        o_err_range;

  modport slave (
    input  i_start, i_d, i_byte, i_byte_valid, i_coeff_ready,
    output o_byte_ready, o_coeff, o_coeff_valid, o_idx, o_last, o_busy, o_err, o_err_range
  );
  modport master (
    output i_start, i_d, i_byte, i_byte_valid, i_coeff_ready,
    input  o_byte_ready, o_coeff, o_coeff_valid, o_idx, o_last, o_busy, o_err, o_err_range
  );
`else
  modport slave (
    input  i_start, i_d, i_byte, i_byte_valid, i_coeff_ready,
    output o_byte_ready, o_coeff, o_coeff_valid, o_idx, o_last, o_busy, o_err
  );
  modport master (
    output i_start, i_d, i_byte, i_byte_valid, i_coeff_ready,
    input  o_byte_ready, o_coeff, o_coeff_valid, o_idx, o_last, o_busy, o_err
  );
`endif
endinterface

// File: rtl/decompress_core.sv
// Combinational Decompress_q(x,d) = round(Q*x / 2^d) for d in 1..11.
module decompress_core
  import kyber_pkg::*;
#(
  parameter int Q = KYBER_Q
) (
  input  logic [10:0] x,
  input  logic [3:0]  d,
  output logic [11:0] coeff
);
  // Adds half an LSB of the 2^d divisor before truncating, i.e. round-half-up.
  function automatic logic [11:0] round_shift(input logic [23:0] prod, input logic [3:0] sh);
    logic [23:0] sum;
    if (sh == 4'd0) return 12'd0;
    sum = prod + (24'd1 << (sh - 4'd1));
    return 12'(sum >> sh);
  endfunction

  logic [23:0] prod;

  assign prod  = 24'(x) * 24'(Q);
  assign coeff = round_shift(prod, d);
endmodule

// File: rtl/decompress_stream.sv
// Streaming ByteDecode_d + Decompress_q: packed bytes in, 256 12-bit coefficients out.
// KYBER_BD12_EN adds d=12 raw pass-through with a sticky o_err_range flag.
module decompress_stream
  import kyber_pkg::*;
#(
  parameter int Q     = KYBER_Q,
  parameter int N     = KYBER_N,
  parameter int BUF_W = 24
) (
  input logic                  i_clk,
  input logic                  i_rst,
  decompress_stream_if.slave   bus
);
  localparam int CNT_W = $clog2(BUF_W + 1);
  localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(BUF_W - 8);
  localparam logic [8:0] N_END  = 9'(N);
  localparam logic [8:0] N_LAST = 9'(N - 1);
`ifdef KYBER_BD12_EN
  localparam int XW = 12;
`else
  localparam int XW = 11;
`endif

  logic [1:0]       state;
  logic [3:0]       d_q;
  logic [BUF_W-1:0] bits, base, bits_n;
  logic [CNT_W-1:0] bitcnt, pos, bitcnt_n;
  logic [8:0]       bytes_rcvd, ext_cnt;
  logic             byte_ready, acc, ext;
  logic [XW-1:0]    x_raw;
  logic [11:0]      core_coeff, coeff_n;
  logic [11:0]      coeff_q;
  logic [7:0]       idx_q;
  logic             valid_q, last_q, err_q;

  assign byte_ready = (state == ST_RUN) && (bitcnt <= FILL_MAX) &&
                      (bytes_rcvd < bytes_per_poly(d_q));
  assign acc = bus.i_byte_valid && byte_ready;
  assign ext = (state != ST_IDLE) && (bitcnt >= CNT_W'(d_q)) && (ext_cnt != N_END) &&
               (!valid_q || bus.i_coeff_ready);

  // Shift out the extracted field first, then append the new byte just above what remains.
  always_comb begin
    base     = ext ? (bits >> d_q) : bits;
    pos      = ext ? (bitcnt - CNT_W'(d_q)) : bitcnt;
    bits_n   = base;
    if (acc) bits_n = base | (BUF_W'(bus.i_byte) << pos);
    bitcnt_n = pos + (acc ? CNT_W'(8) : '0);
  end

  assign x_raw = bits[XW-1:0] & ((XW'(1) << d_q) - XW'(1));

  decompress_core #(.Q(Q)) u_core (
    .x     (x_raw[10:0]),
    .d     (d_q),
    .coeff (core_coeff)
  );

`ifdef KYBER_BD12_EN
  logic err_range_q;
  assign coeff_n         = (d_q == 4'd12) ? x_raw : core_coeff;
  assign bus.o_err_range = err_range_q;
`else
  assign coeff_n = core_coeff;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      d_q        <= '0;
      bits       <= '0;
      bitcnt     <= '0;
      bytes_rcvd <= '0;
      ext_cnt    <= '0;
      coeff_q    <= '0;
      idx_q      <= '0;
      last_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
`ifdef KYBER_BD12_EN
      err_range_q <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: if (bus.i_start) begin
`ifdef KYBER_BD12_EN
          err_range_q <= 1'b0;
`endif
          if (d_legal(bus.i_d)) begin
            d_q        <= bus.i_d;
            bits       <= '0;
            bitcnt     <= '0;
            bytes_rcvd <= '0;
            ext_cnt    <= '0;
            state      <= ST_RUN;
          end else begin
            err_q <= 1'b1;
          end
        end
        ST_RUN:   if (acc && (bytes_rcvd == bytes_per_poly(d_q) - 9'd1)) state <= ST_DRAIN;
        ST_DRAIN: if (valid_q && bus.i_coeff_ready && last_q) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (state != ST_IDLE) begin
        bits   <= bits_n;
        bitcnt <= bitcnt_n;
        if (acc) bytes_rcvd <= bytes_rcvd + 9'd1;
        if (ext) ext_cnt <= ext_cnt + 9'd1;
      end

      // Output register: load on extract, otherwise hold until the handshake empties it.
      if (ext) begin
        coeff_q <= coeff_n;
        idx_q   <= ext_cnt[7:0];
        last_q  <= (ext_cnt == N_LAST);
        valid_q <= 1'b1;
`ifdef KYBER_BD12_EN
        if ((d_q == 4'd12) && (32'(x_raw) >= Q)) err_range_q <= 1'b1;
`endif
      end else if (valid_q && bus.i_coeff_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && ext && (ext_cnt == N_LAST))
      assert (bitcnt_n == '0) else $error("decompress_stream: residual bits after last coefficient");
  end

  assign bus.o_byte_ready  = byte_ready;
  assign bus.o_coeff       = coeff_q;
  assign bus.o_coeff_valid = valid_q;
  assign bus.o_idx         = idx_q;
  assign bus.o_last        = last_q;
  assign bus.o_busy        = (state != ST_IDLE);
  assign bus.o_err         = err_q;
endmodule

// File: tb/tb_decompress_stream.sv
// Directed bench for decompress_stream: known-answer polys, backpressure, illegal d, mid-poly reset.
module tb_decompress_stream;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decompress_stream_if bus();
  decompress_stream dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] mem [384];
  int got [256];
  int nouts;
  int nbytes_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Independent reference: pull bit i*d+b out of the little-endian byte stream.
  function automatic int model(input int d, input int i);
    int x = 0;
    for (int b = 0; b < d; b++) begin
      int p = i * d + b;
      if (mem[p / 8][p % 8]) x |= (1 << b);
    end
    return (x * 3329 + (1 << (d - 1))) >> d;
  endfunction

  task automatic run_poly(input int d, input bit rnd, input int stop_idx, input bit glitch);
    int nb = 32 * d;
    int bp = 0;
    int cyc = 0;
    bit stall = 0;
    bit done = 0;
    logic [11:0] s_coeff;
    logic [7:0]  s_idx;
    logic        s_last;
    nouts = 0;
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_d = 4'(d); bus.i_byte_valid = 1'b0; bus.i_coeff_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    bus.i_byte = mem[0];
    bus.i_byte_valid  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.i_coeff_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      if (stall) begin
        check("hold_valid", 32'(bus.o_coeff_valid), 32'd1);
        check("hold_coeff", 32'(bus.o_coeff), 32'(s_coeff));
        check("hold_idx", 32'(bus.o_idx), 32'(s_idx));
        check("hold_last", 32'(bus.o_last), 32'(s_last));
      end
      if (bus.o_coeff_valid && bus.i_coeff_ready) begin
        check("idx", 32'(bus.o_idx), 32'(nouts));
        check("coeff", 32'(bus.o_coeff), 32'(model(d, nouts)));
        check("last", 32'(bus.o_last), 32'(nouts == 255));
        got[nouts] = int'(bus.o_coeff);
        if (nouts == 255 || nouts == stop_idx) done = 1;
        nouts++;
      end
      stall   = bus.o_coeff_valid && !bus.i_coeff_ready;
      s_coeff = bus.o_coeff;
      s_idx   = bus.o_idx;
      s_last  = bus.o_last;
      if (bus.o_byte_ready && bus.i_byte_valid) bp++;
      @(posedge clk); #1;
      bus.i_byte        = mem[(bp < 384) ? bp : 0];
      bus.i_byte_valid  = (bp < nb) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      bus.i_coeff_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.i_start       = glitch && (cyc == 3);
      if (glitch && cyc == 3) bus.i_d = 4'd1;
      cyc++;
    end
    bus.i_byte_valid = 1'b0; bus.i_start = 1'b0; bus.i_coeff_ready = 1'b1;
    nbytes_acc = bp;
    check("timeout", 32'(done), 32'd1);
    if (stop_idx < 0) begin
      @(negedge clk);
      check("busy_drop", 32'(bus.o_busy), 32'd0);
      check("byte_count", 32'(nbytes_acc), 32'(nb));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_start = 1'b0; bus.i_d = 4'd0; bus.i_byte = 8'd0;
    bus.i_byte_valid = 1'b0; bus.i_coeff_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(bus.o_coeff_valid), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_ready", 32'(bus.o_byte_ready), 32'd0);
    check("rst_err", 32'(bus.o_err), 32'd0);
    check("rst_coeff", 32'(bus.o_coeff), 32'd0);
    check("rst_idx", 32'(bus.o_idx), 32'd0);
    check("rst_last", 32'(bus.o_last), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // d=1: single set bit at position 0
    for (int i = 0; i < 384; i++) mem[i] = 8'h00;
    mem[0] = 8'h01;
    run_poly(1, 1'b0, -1, 1'b0);
    check("d1_idx0", 32'(got[0]), 32'd1665);
    check("d1_idx1", 32'(got[1]), 32'd0);
    check("d1_idx255", 32'(got[255]), 32'd0);

    // d=4: first byte 0xF3 gives nibbles 3 then 15
    for (int i = 0; i < 384; i++) mem[i] = 8'(i * 37 + 5);
    mem[0] = 8'hF3;
    run_poly(4, 1'b0, -1, 1'b0);
    check("d4_idx0", 32'(got[0]), 32'd624);
    check("d4_idx1", 32'(got[1]), 32'd3121);

    // All-ones streams for d=10, 11, 5
    for (int i = 0; i < 384; i++) mem[i] = 8'hFF;
    run_poly(10, 1'b0, -1, 1'b0);
    check("d10_idx0", 32'(got[0]), 32'd3326);
    check("d10_idx255", 32'(got[255]), 32'd3326);
    run_poly(11, 1'b0, -1, 1'b0);
    check("d11_idx0", 32'(got[0]), 32'd3327);
    check("d11_idx255", 32'(got[255]), 32'd3327);
    run_poly(5, 1'b0, -1, 1'b0);
    check("d5_idx0", 32'(got[0]), 32'd3225);
    check("d5_idx128", 32'(got[128]), 32'd3225);

    // Backpressure on both sides with random data, d=11
    for (int i = 0; i < 384; i++) mem[i] = 8'($urandom);
    run_poly(11, 1'b1, -1, 1'b0);

    // Illegal d=3
    @(posedge clk); #1;
    bus.i_start = 1'b1; bus.i_d = 4'd3;
    @(posedge clk); #1;
    bus.i_start = 1'b0;
    @(negedge clk);
    check("bad_d_err", 32'(bus.o_err), 32'd1);
    check("bad_d_busy", 32'(bus.o_busy), 32'd0);
    check("bad_d_ready", 32'(bus.o_byte_ready), 32'd0);
    @(negedge clk);
    check("bad_d_err_pulse", 32'(bus.o_err), 32'd0);
    check("bad_d_busy2", 32'(bus.o_busy), 32'd0);

    // Reset in the middle of a d=10 polynomial, then a clean d=4 run with a stray start
    for (int i = 0; i < 384; i++) mem[i] = 8'($urandom);
    run_poly(10, 1'b0, 100, 1'b0);
    check("mid_count", 32'(nouts), 32'd101);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_valid", 32'(bus.o_coeff_valid), 32'd0);
      check("post_rst_busy", 32'(bus.o_busy), 32'd0);
    end
    for (int i = 0; i < 384; i++) mem[i] = 8'(i * 11 + 3);
    run_poly(4, 1'b0, -1, 1'b1);
    check("restart_count", 32'(nouts), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decompress_stream.md
Name: decompress_stream

Overview:
- Streaming receiver-side counterpart of the combinational compress block.
- Takes a packed byte stream of one polynomial, ByteDecode_d, little-endian bit order.
- Unpacks 256 d-bit values, applies Decompress_q(x,d) = round(q*x/2^d) with q=3329, and emits 256 12-bit coefficients in index order.
- Sits between the ciphertext byte interface and the NTT/poly RAM in the Kyber decapsulation/decryption path.

Parameters:
- Q, 3329, modulus
- N, 256, coefficients per polynomial
- BUF_W, 24, bit-buffer width; must be >= 8+11-1

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start-polynomial pulse; sampled only in IDLE
- i_d  in  4  compression width; legal values 1,4,5,10,11; latched on accepted i_start
- i_byte  in  8  packed input byte
- i_byte_valid  in  1  byte valid
- o_byte_ready  out  1  byte accepted when valid&&ready
- o_coeff  out  12  decompressed coefficient, range 0..3328
- o_coeff_valid  out  1  coefficient valid
- i_coeff_ready  in  1  downstream ready
- o_idx  out  8  index of the current o_coeff, 0..255
- o_last  out  1  high with o_coeff_valid when o_idx==255
- o_busy  out  1  high outside IDLE
- o_err  out  1  one-cycle pulse when i_start is seen with an illegal i_d

Behaviour:
Reset:
- Reset is synchronous and active-high.
- All outputs are 0 and the FSM is in IDLE.
- Bit buffer, bit count, byte counter and coefficient counter are cleared.
- Reset mid-polynomial discards all partial state; no further output occurs until a new i_start.

FSM states: IDLE, RUN, DRAIN.
- IDLE: on i_start with a legal d, latch d, clear the counters and go to RUN.
- IDLE: on i_start with an illegal d, pulse o_err the next cycle and remain in IDLE.
- RUN to DRAIN: when all 32*d bytes are accepted.
- DRAIN to IDLE: when the coefficient with index 255 is handshaken.
- i_start is ignored while o_busy=1.

Byte input:
- o_byte_ready = (state==RUN) && (bitcnt <= BUF_W-8) && (bytes_rcvd < 32*d).
- An accepted byte is appended above the existing bits: buf |= byte << bitcnt.

Extraction:
- Allowed when bitcnt >= d and the output register is empty or being handshaken this cycle.
- x = buf[d-1:0]; buffer shifts right by d.
- Simultaneous accept and extract in one cycle: bitcnt_next = bitcnt + 8 - d.

Arithmetic:
- coeff = (x*Q + 2^(d-1)) >> d.
- Product is 23 bits; use a 24-bit intermediate.
- Result is registered into o_coeff.
- Latency: 1 cycle from bits available to o_coeff_valid.

Output handshake:
- o_coeff, o_idx and o_last hold stable while valid && !ready.
- Full throughput is 1 coefficient per cycle when the byte rate allows.
- 256*d is always a multiple of 8, so bitcnt==0 after index 255. A nonzero bitcnt at that point is an internal assertion failure.

Optional Feature:
KYBER_BD12_EN
- Defined:
  - d=12 is also legal. Output is the raw 12-bit value (ByteDecode_12, no decompression); 384 bytes per polynomial.
  - A raw value >= Q sets sticky o_err_range, cleared on i_start. The value is still output unchanged.
  - The o_err_range port exists only when the macro is defined.
- Undefined: d=12 is illegal (o_err) and the range-check logic is absent.

Decomposition:
- Shared kyber_pkg:
  - constants KYBER_Q=3329 and KYBER_N=256
  - legal-d check function
  - bytes-per-poly function 32*d
  - FSM state encoding
- One sub-module, decompress_core: combinational (x[10:0], d) -> coeff[11:0]. It is reused by other decode paths and unit-testable against the compress vectors.

Test Plan:
- d=1, byte 0x01 then 31 bytes 0x00, i_coeff_ready=1 -> idx0=1665, idx1..255=0; o_last at idx255; o_busy drops the following cycle.
- d=4, first byte 0xF3 -> idx0=624 (x=3), idx1=3121 (x=15); 128 bytes consumed in total.
- d=10, all bytes 0xFF -> every coeff=3326. d=11, all 0xFF -> 3327. d=5, all 0xFF -> 3225. Byte counts: 320, 352 and 160.
- Backpressure: d=11 with random i_coeff_ready and i_byte_valid -> o_coeff/o_idx stable while stalled; 256 outputs in order; no byte lost.
- i_start with i_d=3 -> o_err pulses one cycle, o_busy stays 0, o_byte_ready stays 0.
- i_rst at idx 100 of a d=10 polynomial, then restart with d=4 -> clean 256-coeff output and no stale bits; i_start during RUN is ignored.
